// File: rtl/c1126_mon_pkg.sv
// Shared types and default constants for the c1126 response monitor.
package c1126_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } mon_state_e;

    localparam int unsigned DefRespW = 5;
    localparam int unsigned DefSigW  = 16;
    localparam int unsigned DefCntW  = 16;
    localparam logic [15:0] DefPoly  = 16'h1021;
    localparam logic [15:0] DefSeed  = 16'h0000;

endpackage

// File: rtl/resp_misr.sv
// Multiple-input signature register: shift with polynomial feedback, XOR in the sample.
module resp_misr #(
    parameter int unsigned          RESP_W = 5,
    parameter int unsigned          SIG_W  = 16,
    parameter logic [SIG_W-1:0]     POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]     SEED   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c1126_resp_monitor.sv
// Observation-window monitor: compacts c1126 outputs into a MISR, counts response
// changes, and offers the result over a valid/ready handshake.
module c1126_resp_monitor
    import c1126_mon_pkg::*;
#(
    parameter int unsigned      RESP_W = DefRespW,
    parameter int unsigned      SIG_W  = DefSigW,
    parameter int unsigned      CNT_W  = DefCntW,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DefPoly),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DefSeed)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  win_len,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SIG_W-1:0]  sig_out,
    output logic [CNT_W-1:0]  toggles
);

    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tog_q, tog_d;
    logic [RESP_W-1:0] prev_q, prev_d;
    logic              misr_load, misr_en;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        prev_d    = prev_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d     = win_len;
                    cnt_d     = '0;
                    tog_d     = '0;
                    misr_load = 1'b1;
                    state_d   = (win_len == '0) ? StHold : StRun;
                end
            end
            StRun: begin
                misr_en = 1'b1;
                prev_d  = resp_in;
                cnt_d   = cnt_q + CNT_W'(1);
                // First sample has no predecessor, so it never counts as a toggle.
                if ((cnt_q != '0) && (resp_in != prev_q) && (tog_q != '1)) begin
                    tog_d = tog_q + CNT_W'(1);
                end
                if (cnt_d == len_q) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            tog_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            prev_q  <= prev_d;
        end
    end

    resp_misr #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .en   (misr_en),
        .din  (resp_in),
        .sig  (sig_out)
    );

    assign busy      = (state_q != StIdle);
    assign res_valid = (state_q == StHold);
    assign toggles   = tog_q;

endmodule
